// File: rtl/mult_accumulator.sv
// Multiply-accumulate sequencer: turns each rising edge of a switch into one
// multiplier handshake and adds the signed 64-bit product to a running sum.
module mult_accumulator #(
  parameter int CNT_W  = 8,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sw_begin,
  input  logic             acc_clear,
  output logic             mult_begin,
  input  logic             mult_end,
  input  logic [63:0]      product,
  output logic [63:0]      acc_value,
  output logic [CNT_W-1:0] acc_count,
  output logic             acc_ovf,
  output logic             acc_done
);

  localparam logic [63:0] POS_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {IDLE, RUN, ACC, HOLD} state_t;

  state_t      state, state_nx;
  logic        sw_meta, sw_s;
  logic        first_run, first_run_nx;
  logic        latch_prod, do_acc;
  logic [63:0] prod_r;
  logic [63:0] sum, acc_nx;
  logic        ovf;

  // sw_begin comes straight from a switch, so it is resynchronised before use.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!resetn) begin
      sw_meta <= 1'b0;
      sw_s    <= 1'b0;
    end else begin
      sw_meta <= sw_begin;
      sw_s    <= sw_meta;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    state_nx     = state;
    first_run_nx = 1'b0;
    latch_prod   = 1'b0;
    do_acc       = 1'b0;
    case (state)
      IDLE: if (sw_s) begin
        state_nx     = RUN;
        first_run_nx = 1'b1;
      end
      RUN: begin
        if (acc_clear) begin
          state_nx = HOLD;
        end else if (!first_run && mult_end) begin
          // First RUN cycle skipped: mult_end may still be high from last op.
          latch_prod = 1'b1;
          state_nx   = ACC;
        end
      end
      ACC: begin
        state_nx = HOLD;
        do_acc   = !acc_clear;
      end
      HOLD: if (!sw_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      first_run  <= 1'b0;
      mult_begin <= 1'b0;
      acc_done   <= 1'b0;
    end else begin
      state      <= state_nx;
      first_run  <= first_run_nx;
      mult_begin <= (state_nx == RUN);
      acc_done   <= (state_nx == HOLD);
    end
  end

  // Signed overflow: like-signed addends whose sum flips sign.
  always_comb begin
    sum    = acc_value + prod_r;
    ovf    = (acc_value[63] == prod_r[63]) && (sum[63] != acc_value[63]);
    acc_nx = sum;
    if (ovf && SAT_EN) acc_nx = acc_value[63] ? NEG_MIN : POS_MAX;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prod_r    <= '0;
      acc_value <= '0;
      acc_count <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      if (latch_prod) prod_r <= product;
      if (acc_clear) begin
        acc_value <= '0;
        acc_count <= '0;
        acc_ovf   <= 1'b0;
      end else if (do_acc) begin
        acc_value <= acc_nx;
        if (acc_count != '1) acc_count <= acc_count + CNT_W'(1);
        if (ovf) acc_ovf <= 1'b1;
      end
    end
  end

endmodule
